// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RISC-V core.
//   - Execute-stage operand forwarding selects (M result beats W result, x0 never forwarded)
//   - Load-use stall and taken-branch flush strobes
//   - Multi-cycle Execute sequencer (IDLE/BUSY/DONE) that freezes F/D/E and bubbles M
//   - Saturating count of cycles with StallF asserted
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   Rs1D/Rs2D                  source registers of the Decode instruction
//   Rs1E/Rs2E/RdE              source/destination registers of the Execute instruction
//   RdM/RegWriteM, RdW/RegWriteW  destination and write enable of Memory / Writeback
//   LoadE, PCSrcE, MultiCycE   Execute is a load / taken redirect / multi-cycle op
//   ForwardAE/ForwardBE        00 register file, 01 ResultW, 10 ALUResultM
//   StallF/StallD/StallE       hold PC, F/D and D/E registers
//   FlushD/FlushE/FlushM       clear F/D, D/E and E/M registers
//   McStart/McValid            multi-cycle operand latch pulse / result valid
//   StallCount                 saturating stall-cycle counter
module hazard_ctrl #(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MultiCycE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             McStart,
  output logic             McValid,
  output logic [CNT_W-1:0] StallCount
);

  localparam int unsigned CntBits = $clog2(MC_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntBits-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;

  logic lw_stall;
  logic mc_stall;
  logic mc_start;
  logic mc_valid;

  // Forwarding is purely combinational and is not gated by reset.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
      ForwardAE = 2'b10;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
      ForwardAE = 2'b01;
    end

    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
      ForwardBE = 2'b10;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
      ForwardBE = 2'b01;
    end
  end

  assign lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Multi-cycle sequencer. A redirect in the same cycle kills the op, so no start.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_stall = 1'b0;
    mc_start = 1'b0;
    mc_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MultiCycE && !PCSrcE) begin
          mc_start = 1'b1;
          mc_stall = 1'b1;
          cnt_d    = CntBits'(MC_LATENCY - 1);
          state_d  = StBusy;
        end
      end
      StBusy: begin
        mc_stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntBits'(1);
        end
      end
      StDone: begin
        // Op leaves E at the end of this cycle; MultiCycE here belongs to it, so no restart.
        mc_valid = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobe generation: an active multi-cycle stall overrides load-use and branch flushes.
  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    McStart = 1'b0;
    McValid = 1'b0;
    if (!reset) begin
      McStart = mc_start;
      McValid = mc_valid;
      if (mc_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall || PCSrcE;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (StallF && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  assign StallCount = stall_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule
